// File: rtl/text_attr_gpu.sv
// Text-mode raster generator: character and attribute planes, external font ROM, 3-stage pixel pipeline.
// Define TEXT_ATTR_GPU_CURSOR_EN to add a blinking block cursor (CUR_COL/CUR_ROW registers).
module text_attr_gpu #(
   parameter int COLS     = 80,
   parameter int ROWS     = 30,
   parameter int GLYPH_H  = 16,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  din,
   input  logic [11:0] address,
   input  logic        v_w_en,
   input  logic        a_w_en,
   input  logic        io_w_en,
   input  logic        io_r_en,
   output logic [7:0]  dout,
   output logic [10:0] font_addr,
   input  logic [7:0]  font_data,
   output logic        h_sync,
   output logic        v_sync,
   output logic        R,
   output logic        G,
   output logic        B,
   output logic        blanking_start_interrupt_flag,
   input  logic        blanking_start_interrupt_flag_clr
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int CELLS = COLS * ROWS;
   localparam int XW    = $clog2(H_TOT);
   localparam int YW    = $clog2(V_TOT);
   localparam int AW    = $clog2(CELLS);

   localparam logic [11:0] A_CTRL   = 12'h080;
   localparam logic [11:0] A_SCROLL = 12'h081;
   localparam logic [11:0] A_CCOL   = 12'h082;
   localparam logic [11:0] A_CROW   = 12'h083;

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [7:0]    scroll_q, scroll_d, scroll_sh_q, scroll_sh_d;
   logic          display_en_q, display_en_d, irq_en_q, irq_en_d, flag_q, flag_d;
   logic [7:0]    dout_q, dout_d;
   logic          frame_end, addr_ok;

   logic [AW-1:0] cell_d;
   logic [3:0]    scan_d;
   logic          hs_d, vs_d, act_d;

   logic [7:0]    text_mem [CELLS];
   logic [5:0]    attr_mem [CELLS];

   logic [7:0]    chr_q;
   logic [5:0]    attr1_q, attr2_q;
   logic [2:0]    x1_q, x2_q;
   logic [3:0]    scan1_q;
   logic          hs1_q, vs1_q, act1_q, hs2_q, vs2_q, act2_q;
   logic [2:0]    rgb_q, rgb_d, fg, bg;
   logic          hs3_q, vs3_q, pix;

`ifdef TEXT_ATTR_GPU_CURSOR_EN
   logic [7:0]    cur_col_q, cur_col_d, cur_row_q, cur_row_d;
   logic [5:0]    blink_q, blink_d;
   logic          cur_d, cur1_q, cur2_q;
`endif

   // Raster position, cell lookup and raw sync/active for the current counter cycle
   always_comb begin
      int row_i, col_i, vrow_i;
      x_d = x_q + XW'(1);
      y_d = y_q;
      frame_end = 1'b0;
      if (int'(x_q) == H_TOT - 1) begin
         x_d = '0;
         if (int'(y_q) == V_TOT - 1) begin
            y_d = '0;
            frame_end = 1'b1;
         end else begin
            y_d = y_q + YW'(1);
         end
      end

      row_i = int'(y_q) / GLYPH_H;
      col_i = int'(x_q) / 8;
`ifdef TEXT_ATTR_GPU_CURSOR_EN
      cur_d = (col_i == int'(cur_col_q)) && (row_i == int'(cur_row_q)) && blink_q[5];
`endif
      // Blanking-region positions are clamped so the RAM index always stays inside the planes
      if (row_i >= ROWS) row_i = 0;
      if (col_i >= COLS) col_i = 0;
      vrow_i = row_i + int'(scroll_sh_q);
      if (vrow_i >= ROWS) vrow_i = vrow_i - ROWS;
      cell_d = AW'(vrow_i * COLS + col_i);
      scan_d = 4'(int'(y_q) % GLYPH_H);

      hs_d  = !((int'(x_q) >= H_ACTIVE + H_FP) && (int'(x_q) < H_ACTIVE + H_FP + H_SYNC));
      vs_d  = !((int'(y_q) >= V_ACTIVE + V_FP) && (int'(y_q) < V_ACTIVE + V_FP + V_SYNC));
      act_d = (int'(x_q) < H_ACTIVE) && (int'(y_q) < V_ACTIVE);
      addr_ok = int'(address) < CELLS;
   end

   // Register file and frame interrupt flag
   always_comb begin
      scroll_d     = scroll_q;
      scroll_sh_d  = frame_end ? scroll_q : scroll_sh_q;
      display_en_d = display_en_q;
      irq_en_d     = irq_en_q;
      flag_d       = flag_q;
      dout_d       = dout_q;
`ifdef TEXT_ATTR_GPU_CURSOR_EN
      cur_col_d = cur_col_q;
      cur_row_d = cur_row_q;
      blink_d   = frame_end ? blink_q + 6'd1 : blink_q;
`endif
      if (irq_en_q && x_q == '0 && int'(y_q) == V_ACTIVE) flag_d = 1'b1;
      if (io_w_en) begin
         case (address)
            A_CTRL: begin
               display_en_d = din[2];
               irq_en_d     = din[1];
               flag_d       = din[0];
            end
            A_SCROLL: if (int'(din) < ROWS) scroll_d = din;
`ifdef TEXT_ATTR_GPU_CURSOR_EN
            A_CCOL: cur_col_d = din;
            A_CROW: cur_row_d = din;
`endif
            default: ;
         endcase
      end
      if (blanking_start_interrupt_flag_clr) flag_d = 1'b0;
      if (io_r_en) begin
         case (address)
            A_CTRL:   dout_d = {5'd0, display_en_q, irq_en_q, flag_q};
            A_SCROLL: dout_d = scroll_q;
`ifdef TEXT_ATTR_GPU_CURSOR_EN
            A_CCOL:   dout_d = cur_col_q;
            A_CROW:   dout_d = cur_row_q;
`else
            A_CCOL:   dout_d = 8'd0;
            A_CROW:   dout_d = 8'd0;
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      font_addr = {7'(chr_q - 8'd32), scan1_q};
      fg  = attr2_q[2:0];
      bg  = attr2_q[5:3];
`ifdef TEXT_ATTR_GPU_CURSOR_EN
      if (cur2_q) begin
         fg = attr2_q[5:3];
         bg = attr2_q[2:0];
      end
`endif
      pix   = font_data[3'd7 - x2_q];
      rgb_d = (act2_q && display_en_q) ? (pix ? fg : bg) : 3'b000;
   end

   // Planes are not reset; contents survive rst
   always_ff @(posedge clk) begin
      if (v_w_en && addr_ok) text_mem[address[AW-1:0]] <= din;
      if (a_w_en && addr_ok) attr_mem[address[AW-1:0]] <= {din[6:4], din[2:0]};
      chr_q   <= text_mem[cell_d];
      attr1_q <= attr_mem[cell_d];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q          <= '0;
         y_q          <= '0;
         scroll_q     <= '0;
         scroll_sh_q  <= '0;
         display_en_q <= 1'b1;
         irq_en_q     <= 1'b0;
         flag_q       <= 1'b0;
         dout_q       <= '0;
         x1_q    <= '0;  scan1_q <= '0;  hs1_q <= 1'b1;  vs1_q <= 1'b1;  act1_q <= 1'b0;
         x2_q    <= '0;  attr2_q <= '0;  hs2_q <= 1'b1;  vs2_q <= 1'b1;  act2_q <= 1'b0;
         rgb_q   <= '0;  hs3_q   <= 1'b1; vs3_q <= 1'b1;
`ifdef TEXT_ATTR_GPU_CURSOR_EN
         cur_col_q <= '0;
         cur_row_q <= '0;
         blink_q   <= '0;
         cur1_q    <= 1'b0;
         cur2_q    <= 1'b0;
`endif
      end else begin
         x_q          <= x_d;
         y_q          <= y_d;
         scroll_q     <= scroll_d;
         scroll_sh_q  <= scroll_sh_d;
         display_en_q <= display_en_d;
         irq_en_q     <= irq_en_d;
         flag_q       <= flag_d;
         dout_q       <= dout_d;
         x1_q    <= x_q[2:0]; scan1_q <= scan_d;  hs1_q <= hs_d;  vs1_q <= vs_d;  act1_q <= act_d;
         x2_q    <= x1_q;     attr2_q <= attr1_q; hs2_q <= hs1_q; vs2_q <= vs1_q; act2_q <= act1_q;
         rgb_q   <= rgb_d;    hs3_q   <= hs2_q;   vs3_q <= vs2_q;
`ifdef TEXT_ATTR_GPU_CURSOR_EN
         cur_col_q <= cur_col_d;
         cur_row_q <= cur_row_d;
         blink_q   <= blink_d;
         cur1_q    <= cur_d;
         cur2_q    <= cur1_q;
`endif
      end
   end

   assign dout   = dout_q;
   assign h_sync = hs3_q;
   assign v_sync = vs3_q;
   assign R      = rgb_q[0];
   assign G      = rgb_q[1];
   assign B      = rgb_q[2];
   assign blanking_start_interrupt_flag = flag_q;

endmodule

// File: tb/tb_text_attr_gpu.sv
// Directed bench for text_attr_gpu on a reduced 4x4-cell raster (40x12 clocks per frame).
module tb_text_attr_gpu;
   localparam int COLS = 4, ROWS = 4, GLYPH_H = 2;
   localparam int H_ACTIVE = 32, H_FP = 2, H_SYNC = 4, H_BP = 2;
   localparam int V_ACTIVE = 8, V_FP = 1, V_SYNC = 2, V_BP = 1;
   localparam int H_TOT = 40, V_TOT = 12, FRAME = H_TOT * V_TOT;

   logic        clk = 1'b0, rst = 1'b1;
   logic [7:0]  din = '0;
   logic [11:0] address = '0;
   logic        v_w_en = 1'b0, a_w_en = 1'b0, io_w_en = 1'b0, io_r_en = 1'b0;
   logic [7:0]  dout, font_data = '0;
   logic [10:0] font_addr;
   logic        h_sync, v_sync, R, G, B, flag, flag_clr = 1'b0;

   int vectors = 0, miscompares = 0;
   int bx = 0, by = 0, bfr = 0;

   text_attr_gpu #(
      .COLS(COLS), .ROWS(ROWS), .GLYPH_H(GLYPH_H),
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) dut (
      .clk(clk), .rst(rst), .din(din), .address(address),
      .v_w_en(v_w_en), .a_w_en(a_w_en), .io_w_en(io_w_en), .io_r_en(io_r_en),
      .dout(dout), .font_addr(font_addr), .font_data(font_data),
      .h_sync(h_sync), .v_sync(v_sync), .R(R), .G(G), .B(B),
      .blanking_start_interrupt_flag(flag),
      .blanking_start_interrupt_flag_clr(flag_clr)
   );

   always #5 clk = ~clk;

   // Stand-in font ROM with one clock of read latency
   function automatic logic [7:0] glyph(input logic [10:0] a);
      return {a[10:4], 1'b1} ^ {a[3:0], 4'b0101};
   endfunction

   always @(posedge clk) font_data <= glyph(font_addr);

   // Reference raster position and frame number
   always @(posedge clk) begin
      if (rst) begin
         bx <= 0; by <= 0; bfr <= 0;
      end else if (bx == H_TOT - 1) begin
         bx <= 0;
         if (by == V_TOT - 1) begin
            by <= 0; bfr <= bfr + 1;
         end else by <= by + 1;
      end else bx <= bx + 1;
   end

   function automatic logic [2:0] exp_rgb(input logic [7:0] ch, input logic [7:0] at,
                                          input int scan, input int i, input logic sw);
      logic [7:0] g;
      logic [2:0] fg, bg, c;
      g  = glyph({7'(ch - 8'd32), 4'(scan)});
      fg = sw ? at[6:4] : at[2:0];
      bg = sw ? at[2:0] : at[6:4];
      c  = g[7 - i] ? fg : bg;
      return {c[0], c[1], c[2]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_pos(input int px, input int py);
      int n = 0;
      while (!(bx == px && by == py) && n < 2 * FRAME) begin
         @(negedge clk);
         n++;
      end
      if (!(bx == px && by == py)) begin
         miscompares++;
         $display("FAIL wait_pos(%0d,%0d): not reached within %0d cycles", px, py, n);
      end
   endtask

   task automatic at_pixel(input int px, input int py);
      wait_pos(px, py);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_row8(input int px, input int py, input logic [7:0] ch,
                             input logic [7:0] at, input logic sw, input string tag);
      at_pixel(px, py);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s px%0d", tag, i), {29'd0, R, G, B},
               {29'd0, exp_rgb(ch, at, py % GLYPH_H, i, sw)});
         @(negedge clk);
      end
   endtask

   task automatic cell_write(input int a, input logic [7:0] d, input logic v, input logic at);
      address = 12'(a); din = d; v_w_en = v; a_w_en = at;
      @(negedge clk);
      v_w_en = 1'b0; a_w_en = 1'b0;
   endtask

   task automatic io_write(input logic [11:0] a, input logic [7:0] d);
      address = a; din = d; io_w_en = 1'b1;
      @(negedge clk);
      io_w_en = 1'b0;
   endtask

   task automatic io_read(input logic [11:0] a, input logic [7:0] exp, input string tag);
      address = a; io_r_en = 1'b1;
      @(negedge clk);
      io_r_en = 1'b0;
      check(tag, {24'd0, dout}, {24'd0, exp});
   endtask

   initial begin
      int n, hl, vl;
      logic prev, done;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst dout", {24'd0, dout}, 32'h0);
      check("rst rgb", {29'd0, R, G, B}, 32'h0);
      check("rst h_sync", {31'd0, h_sync}, 32'h1);
      check("rst v_sync", {31'd0, v_sync}, 32'h1);
      check("rst flag", {31'd0, flag}, 32'h0);
      rst = 1'b0;
`ifdef TEXT_ATTR_GPU_CURSOR_EN
      io_write(12'h082, 8'd3);
`endif
      io_read(12'h080, 8'h04, "ctrl after rst");
      io_read(12'h081, 8'h00, "scroll after rst");

      // One full frame between v_sync falling edges
      n = 0;
      prev = v_sync;
      while (!(prev && !v_sync) && n < 2 * FRAME) begin
         prev = v_sync; @(negedge clk); n++;
      end
      n = 0; hl = 0; vl = 0; done = 1'b0;
      while (!done && n < 2 * FRAME) begin
         hl += int'(!h_sync); vl += int'(!v_sync); n++;
         prev = v_sync;
         @(negedge clk);
         if (prev && !v_sync) done = 1'b1;
      end
      check("frame clocks", n, FRAME);
      check("h_sync low clocks", hl, H_SYNC * V_TOT);
      check("v_sync low clocks", vl, V_SYNC * H_TOT);
      check("flag idle irq off", {31'd0, flag}, 32'h0);

      at_pixel(H_ACTIVE + H_FP - 1, 0);
      check("h_sync before", {31'd0, h_sync}, 32'h1);
      @(negedge clk);
      check("h_sync start", {31'd0, h_sync}, 32'h0);

      cell_write(0, 8'h41, 1'b1, 1'b0);
      cell_write(0, 8'h14, 1'b0, 1'b1);
      cell_write(4, 8'h42, 1'b1, 1'b0);
      cell_write(4, 8'h25, 1'b0, 1'b1);
      cell_write(15, 8'h43, 1'b1, 1'b1);
      check_row8(0, 0, 8'h41, 8'h14, 1'b0, "cell0 scan0");
      check_row8(0, 1, 8'h41, 8'h14, 1'b0, "cell0 scan1");

      io_write(12'h080, 8'h00);
      at_pixel(0, 0);
      check("display off", {29'd0, R, G, B}, 32'h0);
      io_write(12'h080, 8'h04);
      at_pixel(H_ACTIVE, 0);
      check("inactive black", {29'd0, R, G, B}, 32'h0);

      cell_write(COLS * ROWS, 8'h7f, 1'b1, 1'b1);
      check_row8(24, 6, 8'h43, 8'h43, 1'b0, "cell15 kept");
      check_row8(0, 0, 8'h41, 8'h14, 1'b0, "cell0 kept");

      wait_pos(0, 1);
      io_write(12'h081, 8'd1);
      check_row8(0, 2, 8'h42, 8'h25, 1'b0, "scroll same frame");
      check_row8(0, 0, 8'h42, 8'h25, 1'b0, "scroll next frame");
      check_row8(0, 6, 8'h41, 8'h14, 1'b0, "scroll wrap");
      io_write(12'h081, 8'd4);
      io_read(12'h081, 8'd1, "scroll reject");
      io_write(12'h081, 8'd0);

      io_write(12'h080, 8'h06);
      wait_pos(0, V_ACTIVE);
      check("flag before set", {31'd0, flag}, 32'h0);
      @(negedge clk);
      check("flag set", {31'd0, flag}, 32'h1);
      io_read(12'h080, 8'h07, "ctrl with flag");
      flag_clr = 1'b1; @(negedge clk); flag_clr = 1'b0;
      check("flag clr", {31'd0, flag}, 32'h0);
      wait_pos(0, V_ACTIVE);
      flag_clr = 1'b1; @(negedge clk); flag_clr = 1'b0;
      check("clr beats set", {31'd0, flag}, 32'h0);
      wait_pos(0, V_ACTIVE);
      io_write(12'h080, 8'h06);
      check("ctrl write beats set", {31'd0, flag}, 32'h0);
      io_write(12'h080, 8'h07);
      check("ctrl write sets flag", {31'd0, flag}, 32'h1);
      io_write(12'h080, 8'h04);

`ifdef TEXT_ATTR_GPU_CURSOR_EN
      io_read(12'h082, 8'd3, "cur_col read");
`else
      io_write(12'h082, 8'd5);
      io_read(12'h082, 8'd0, "cur_col absent");
`endif
      io_read(12'h080, 8'h04, "ctrl read");
      io_read(12'h090, 8'h04, "unmapped keeps dout");

      wait_pos(20, 5);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      check_row8(0, 0, 8'h41, 8'h14, 1'b0, "ram after rst");

`ifdef TEXT_ATTR_GPU_CURSOR_EN
      io_write(12'h082, 8'd0);
      io_write(12'h083, 8'd0);
      n = 0;
      while (!(bfr % 64 == 32 && bx == 0 && by == 0) && n < 70 * FRAME) begin
         @(negedge clk); n++;
      end
      check_row8(0, 0, 8'h41, 8'h14, 1'b1, "cursor on");
      n = 0;
      while (!(bfr % 64 == 0 && bx == 0 && by == 0) && n < 70 * FRAME) begin
         @(negedge clk); n++;
      end
      check_row8(0, 0, 8'h41, 8'h14, 1'b0, "cursor off");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
